io_exec_unit: RTL and testbench
===============================

Name: io_exec_unit

Overview:
- Consumer end of the IO/load-store issue queue's dequeue interface: accepts one issued memory instruction at a time, performs the memory access over a simple req/resp bus, and drives one writeback/wakeup port.
- Blocking, single-outstanding design, matching the queue's in-order issue. `issue_ready` back-pressures the queue while an access is in flight.
- Register operand values come from the regfile read stage placed between the queue and this block.

Parameters:
- XLEN, 64, data/address width
- PREG_W, 7, physical register index width
- ROB_LOG, 6, ROB index width (excluding wrap flag)

Ports:
- clock  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- issue_valid  in  1  issued instruction valid
- issue_ready  out  1  block can accept an instruction
- issue_src1  in  XLEN  base register value
- issue_src2  in  XLEN  store data value
- issue_imm  in  XLEN  address offset
- issue_prd  in  PREG_W  destination physical register
- issue_need_to_wb  in  1  writes a register
- issue_is_load  in  1  load instruction
- issue_is_store  in  1  store instruction
- issue_ls_size  in  4  one-hot size: 0001=B, 0010=H, 0100=W, 1000=D
- issue_is_unsigned  in  1  zero-extend load data
- issue_robidx_flag  in  1  ROB wrap flag
- issue_robidx  in  ROB_LOG  ROB index
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  8-byte aligned address ({addr[XLEN-1:3],3'b0})
- mem_req_wen  out  1  1=store
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wmask  out  8  byte-enable mask
- mem_resp_valid  in  1  response/ack valid, one cycle
- mem_resp_data  in  XLEN  aligned 8-byte read data
- wb_valid  out  1  writeback pulse
- wb_need_to_wb  out  1  register write / wakeup enable
- wb_prd  out  PREG_W  destination register
- wb_data  out  XLEN  load result (0 for stores)
- wb_robidx_flag  out  1  ROB flag of completing instr
- wb_robidx  out  ROB_LOG  ROB index of completing instr
- flush_valid  in  1  redirect flush
- flush_robidx_flag  in  1  flush ROB flag
- flush_robidx  in  ROB_LOG  flush ROB index

Behaviour:
- Reset values: state=IDLE; all outputs 0; `issue_ready`=1 in IDLE after reset.
- Kill test: `kill = flush_valid & ((flush_robidx_flag ^ held_flag) ^ (flush_robidx < held_robidx))`. This is the same younger-than comparison the issue queue uses.
- `issue_ready` = (state==IDLE).
- Accept = issue_valid & issue_ready & ~kill(issue robidx). A killed instruction offered during a flush is dropped, and state stays IDLE.
- On accept, latch all fields, then go to REQ:
  - addr = src1 + imm, modulo 2^XLEN.
  - off = addr[2:0].
  - size mask: B=0x01, H=0x03, W=0x0F, D=0xFF.
  - wmask = (size mask << off), truncated to 8 bits.
  - wdata = src2 << (off*8).
  - No misalignment check: the instruction is required to fit in the 8-byte line.
- States:
  - IDLE: waiting for issue.
  - REQ: `mem_req_valid`=1 with stable fields until the handshake.
    - kill & ~mem_req_ready -> IDLE, request withdrawn, no wb.
    - mem_req_ready & kill -> DRAIN.
    - mem_req_ready & ~kill -> WAIT.
  - WAIT: awaiting mem_resp_valid.
    - kill -> DRAIN.
    - resp & kill in the same cycle -> IDLE, no wb.
    - resp & ~kill -> IDLE, and the wb registers load.
  - DRAIN: request already issued but the instruction is dead. Wait for mem_resp_valid, discard it, go to IDLE; no wb.
- Writeback:
  - Registered; `wb_valid` pulses for exactly 1 cycle, the cycle after the accepted response.
  - Load: raw = resp_data >> (off*8), then sign- or zero-extend from the size per is_unsigned. D ignores is_unsigned.
  - Store: wb_data=0 and wb_need_to_wb=0. The pulse signals completion only.
  - wb_need_to_wb = latched need_to_wb & is_load.
- Latency: issue accept at cycle T, req at T+1 at the earliest; resp at cycle R gives wb_valid at R+1. Throughput is 1 access per (req+resp+1) cycles.
- A new issue may be accepted in the same cycle `wb_valid` is high (state is already IDLE).
- mem_resp_valid in IDLE/REQ is ignored.
- Async reset mid-access: return to IDLE immediately and clear wb_valid/mem_req_valid. The memory side is reset by the same reset_n.

Test Plan:
- Load doubleword: src1=0x1000, imm=0x8, ls_size=1000, resp_data=0x8877665544332211 -> mem_req_addr=0x1008, wen=0, wb_valid one cycle after resp, wb_data=0x8877665544332211, wb_need_to_wb=1.
- Signed byte load: addr=0x2003, resp_data=0x00000000_80000000, is_unsigned=0 -> wb_data=0xFFFFFFFFFFFFFF80. Same with is_unsigned=1 -> 0x80.
- Store word: addr=0x3004, src2=0xDEADBEEF -> wmask=0xF0, wdata=0xDEADBEEF_00000000, wen=1. After ack: wb_valid=1, wb_need_to_wb=0, wb_data=0.
- Back-pressure: mem_req_ready low for 5 cycles -> req fields stable, issue_ready=0 throughout, exactly one handshake.
- Flush in WAIT: held robidx flag=0/idx=10, flush flag=0/idx=5 -> DRAIN; the response is consumed with no wb_valid; issue_ready=1 the cycle after the resp. Repeat with flush idx=12 -> no kill, normal wb.
- Flush with concurrent issue: issue robidx 20, flush idx 3, same flags -> not accepted, no mem_req_valid. Next-cycle issue with no flush -> accepted.

Source files
------------

// File: rtl/io_exec_unit_if.sv
// io_exec_unit_if: issue, memory and writeback/flush bundle around io_exec_unit.
//   master : the execution unit (consumes issue, masters the memory bus,
//            drives writeback).
//   slave  : its environment (issue queue / regfile read, memory, ROB, flush).
interface io_exec_unit_if #(
  parameter int XLEN    = 64,
  parameter int PREG_W  = 7,
  parameter int ROB_LOG = 6
);
  // issue side
  logic               issue_valid;
  logic               issue_ready;
  logic [XLEN-1:0]    issue_src1;
  logic [XLEN-1:0]    issue_src2;
  logic [XLEN-1:0]    issue_imm;
  logic [PREG_W-1:0]  issue_prd;
  logic               issue_need_to_wb;
  logic               issue_is_load;
  logic               issue_is_store;
  logic [3:0]         issue_ls_size;
  logic               issue_is_unsigned;
  logic               issue_robidx_flag;
  logic [ROB_LOG-1:0] issue_robidx;
  // memory bus
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_req_wen;
  logic [XLEN-1:0]    mem_req_wdata;
  logic [7:0]         mem_req_wmask;
  logic               mem_resp_valid;
  logic [XLEN-1:0]    mem_resp_data;
  // writeback / wakeup
  logic               wb_valid;
  logic               wb_need_to_wb;
  logic [PREG_W-1:0]  wb_prd;
  logic [XLEN-1:0]    wb_data;
  logic               wb_robidx_flag;
  logic [ROB_LOG-1:0] wb_robidx;
  // redirect flush
  logic               flush_valid;
  logic               flush_robidx_flag;
  logic [ROB_LOG-1:0] flush_robidx;

  modport master (
    input  issue_valid, issue_src1, issue_src2, issue_imm, issue_prd,
           issue_need_to_wb, issue_is_load, issue_is_store, issue_ls_size,
           issue_is_unsigned, issue_robidx_flag, issue_robidx,
    output issue_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output wb_valid, wb_need_to_wb, wb_prd, wb_data, wb_robidx_flag, wb_robidx,
    input  flush_valid, flush_robidx_flag, flush_robidx
  );

  modport slave (
    output issue_valid, issue_src1, issue_src2, issue_imm, issue_prd,
           issue_need_to_wb, issue_is_load, issue_is_store, issue_ls_size,
           issue_is_unsigned, issue_robidx_flag, issue_robidx,
    input  issue_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  wb_valid, wb_need_to_wb, wb_prd, wb_data, wb_robidx_flag, wb_robidx,
    output flush_valid, flush_robidx_flag, flush_robidx
  );
endinterface

// File: rtl/io_exec_unit.sv
// io_exec_unit: blocking, single-outstanding load/store execution unit.
// Takes one issued memory op, performs one aligned 8-byte access on the
// req/resp bus, and pulses one writeback/wakeup.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   bus (master)   : issue dequeue, memory req/resp, writeback, flush
module io_exec_unit #(
  parameter int XLEN    = 64,
  parameter int PREG_W  = 7,
  parameter int ROB_LOG = 6
) (
  input  logic          clock,
  input  logic          reset_n,
  io_exec_unit_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0]    addr;   // full byte address; low 3 bits = lane offset
    logic [XLEN-1:0]    wdata;  // lane-shifted store data
    logic [7:0]         wmask;
    logic [3:0]         size;
    logic               uns;
    logic               is_load;
    logic               is_store;
    logic               need_wb;
    logic [PREG_W-1:0]  prd;
    logic               rob_flag;
    logic [ROB_LOG-1:0] rob_idx;
  } op_t;

  logic [1:0]      state;
  op_t             op, op_new;
  logic            kill_new, kill_held, accept;
  logic [XLEN-1:0] addr_new;
  logic [7:0]      smask_new;
  logic [5:0]      sh_new, sh_held;
  logic [XLEN-1:0] raw, ld_data;

  // Younger-than test shared with the issue queue: a flush kills anything
  // whose ROB index lies after the flush point, wrap flag included.
  assign kill_new  = bus.flush_valid &
                     ((bus.flush_robidx_flag ^ bus.issue_robidx_flag) ^
                      (bus.flush_robidx < bus.issue_robidx));
  assign kill_held = bus.flush_valid &
                     ((bus.flush_robidx_flag ^ op.rob_flag) ^
                      (bus.flush_robidx < op.rob_idx));

  assign accept = bus.issue_valid & (state == IDLE) & ~kill_new;

  always_comb begin
    addr_new = bus.issue_src1 + bus.issue_imm;
    sh_new   = {addr_new[2:0], 3'b000};
    case (bus.issue_ls_size)
      4'b0001: smask_new = 8'h01;
      4'b0010: smask_new = 8'h03;
      4'b0100: smask_new = 8'h0F;
      default: smask_new = 8'hFF;
    endcase
    op_new.addr     = addr_new;
    op_new.wdata    = bus.issue_src2 << sh_new;
    // access is guaranteed to fit the line, so bits shifted out are never live
    op_new.wmask    = smask_new << addr_new[2:0];
    op_new.size     = bus.issue_ls_size;
    op_new.uns      = bus.issue_is_unsigned;
    op_new.is_load  = bus.issue_is_load;
    op_new.is_store = bus.issue_is_store;
    op_new.need_wb  = bus.issue_need_to_wb;
    op_new.prd      = bus.issue_prd;
    op_new.rob_flag = bus.issue_robidx_flag;
    op_new.rob_idx  = bus.issue_robidx;
  end

  // load lane extraction + extension
  assign sh_held = {op.addr[2:0], 3'b000};
  assign raw     = bus.mem_resp_data >> sh_held;

  always_comb begin
    case (op.size)
      4'b0001: ld_data = op.uns ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                : {{(XLEN-8){raw[7]}}, raw[7:0]};
      4'b0010: ld_data = op.uns ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                : {{(XLEN-16){raw[15]}}, raw[15:0]};
      4'b0100: ld_data = op.uns ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: ld_data = raw;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      op                 <= '0;
      bus.wb_valid       <= 1'b0;
      bus.wb_need_to_wb  <= 1'b0;
      bus.wb_prd         <= '0;
      bus.wb_data        <= '0;
      bus.wb_robidx_flag <= 1'b0;
      bus.wb_robidx      <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op    <= op_new;
          state <= REQ;
        end
        REQ: begin
          // killed before handshake: withdraw; killed at handshake: the
          // access is on the bus, so its response must still be swallowed
          if (kill_held)              state <= bus.mem_req_ready ? DRAIN : IDLE;
          else if (bus.mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state <= IDLE;
            if (!kill_held) begin
              bus.wb_valid       <= 1'b1;
              bus.wb_need_to_wb  <= op.need_wb & op.is_load;
              bus.wb_prd         <= op.prd;
              bus.wb_data        <= op.is_load ? ld_data : '0;
              bus.wb_robidx_flag <= op.rob_flag;
              bus.wb_robidx      <= op.rob_idx;
            end
          end else if (kill_held) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (bus.mem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready   = (state == IDLE);
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = {op.addr[XLEN-1:3], 3'b000};
  assign bus.mem_req_wen   = op.is_store;
  assign bus.mem_req_wdata = op.wdata;
  assign bus.mem_req_wmask = op.wmask;

endmodule

// File: tb/tb_io_exec_unit.sv
module tb_io_exec_unit;
  localparam int XLEN = 64, PREG_W = 7, ROB_LOG = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  io_exec_unit_if #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_LOG(ROB_LOG)) bus();
  io_exec_unit #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_LOG(ROB_LOG)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask; logic wen; } req_t;
  typedef struct { logic need; logic [6:0] prd; logic [63:0] data; logic flag; logic [5:0] idx; } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int checks = 0, errors = 0, hs_count = 0;
  int stall_cfg = 0, rmin = 0, rmax = 0;

  // byte-addressed memories: ref_mem follows the spec's semantics,
  // bus_mem is whatever the DUT actually wrote over the bus
  logic [7:0] ref_mem [bit [63:0]];
  logic [7:0] bus_mem [bit [63:0]];

  function automatic logic [7:0] dflt(input bit [63:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction
  function automatic logic [7:0] ref_rd(input bit [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] bus_rd(input bit [63:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++; errors++;
    $display("FAIL %s", name);
  endtask

  task automatic preload(input bit [63:0] a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      ref_mem[a + 64'(i)] = v[8*i +: 8];
      bus_mem[a + 64'(i)] = v[8*i +: 8];
    end
  endtask

  // Reference: compute expected request and writeback from the op, then offer it.
  task automatic issue(input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] imm,
                       input int n, input bit uns, input bit st, input bit nw,
                       input logic [6:0] prd, input bit fl, input logic [5:0] idx,
                       input bit want_req, input bit want_wb);
    logic [63:0] a, val, wd;
    logic [7:0] wm;
    int off, cnt;
    bit acc;
    req_t rq;
    wb_t wb;
    a = s1 + imm;
    off = int'(a[2:0]);
    wm = '0; wd = '0; val = '0;
    for (int i = 0; i < n; i++) wm[off+i] = 1'b1;
    for (int i = 0; i < 8 - off; i++) wd[8*(off+i) +: 8] = s2[8*i +: 8];
    rq.addr = {a[63:3], 3'b000}; rq.wdata = wd; rq.wmask = wm; rq.wen = st;
    if (st) begin
      if (want_req) for (int i = 0; i < n; i++) ref_mem[a + 64'(i)] = s2[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) val[8*i +: 8] = ref_rd(a + 64'(i));
      if (!uns && n < 8 && val[8*n-1] == 1'b1)
        for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
    end
    wb.need = nw & !st; wb.prd = prd; wb.data = st ? 64'd0 : val;
    wb.flag = fl; wb.idx = idx;
    if (want_req) req_q.push_back(rq);
    if (want_wb)  wb_q.push_back(wb);

    @(posedge clock); #1;
    bus.issue_valid = 1'b1; bus.issue_src1 = s1; bus.issue_src2 = s2; bus.issue_imm = imm;
    bus.issue_prd = prd; bus.issue_need_to_wb = nw; bus.issue_is_load = !st;
    bus.issue_is_store = st; bus.issue_ls_size = 4'(n); bus.issue_is_unsigned = uns;
    bus.issue_robidx_flag = fl; bus.issue_robidx = idx;
    cnt = 0; acc = 1'b0;
    while (!acc && cnt < 200) begin
      @(negedge clock); acc = bus.issue_ready;
      @(posedge clock); #1;
      cnt++;
    end
    if (!acc) fail_now("issue_accept_timeout");
    bus.issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while ((req_q.size() != 0 || wb_q.size() != 0 || !bus.issue_ready) && cnt < 500) begin
      @(negedge clock); cnt++;
    end
    if (cnt >= 500) fail_now("wait_idle_timeout");
    @(negedge clock);
  endtask

  // memory responder: stalls ready, returns aligned read data / applies writes
  initial begin : responder
    bit v, r, p_act, in_req;
    int dly, stall_left;
    req_t cur, pend;
    p_act = 0; in_req = 0; dly = 0; stall_left = 0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    forever begin
      @(negedge clock);
      v = bus.mem_req_valid; r = bus.mem_req_ready;
      cur.addr = bus.mem_req_addr; cur.wdata = bus.mem_req_wdata;
      cur.wmask = bus.mem_req_wmask; cur.wen = bus.mem_req_wen;
      @(posedge clock); #1;
      bus.mem_resp_valid = 1'b0;
      if (!reset_n) begin
        p_act = 0; in_req = 0; bus.mem_req_ready = 1'b0;
      end else begin
        if (v && r) begin
          p_act = 1; pend = cur; in_req = 0; bus.mem_req_ready = 1'b0;
          dly = int'($urandom_range(rmax, rmin));
          if (cur.wen)
            for (int i = 0; i < 8; i++)
              if (cur.wmask[i]) bus_mem[cur.addr + 64'(i)] = cur.wdata[8*i +: 8];
        end else if (v) begin
          if (!in_req) begin in_req = 1; stall_left = stall_cfg; end
          if (stall_left == 0) bus.mem_req_ready = 1'b1;
          else stall_left--;
        end else begin
          in_req = 0; bus.mem_req_ready = 1'b0;
        end
        if (p_act) begin
          if (dly == 0) begin
            bus.mem_resp_valid = 1'b1;
            for (int i = 0; i < 8; i++) bus.mem_resp_data[8*i +: 8] = bus_rd(pend.addr + 64'(i));
            p_act = 0;
          end else dly--;
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a request or writeback
  initial begin : monitor
    bit pv, phs, presp;
    req_t prev, e;
    wb_t w;
    pv = 0; phs = 0; presp = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv = 0; phs = 0; presp = 0;
      end else begin
        if (bus.mem_req_valid) begin
          chk("issue_ready_low_in_req", bus.issue_ready, 0);
          if (pv && !phs) begin
            chk("req_addr_stable", bus.mem_req_addr, prev.addr);
            chk("req_wdata_stable", bus.mem_req_wdata, prev.wdata);
            chk("req_wmask_stable", bus.mem_req_wmask, prev.wmask);
            chk("req_wen_stable", bus.mem_req_wen, prev.wen);
          end
          if (bus.mem_req_ready) begin
            hs_count++;
            if (req_q.size() == 0) fail_now("req_unexpected");
            else begin
              e = req_q.pop_front();
              chk("req_addr", bus.mem_req_addr, e.addr);
              chk("req_wen", bus.mem_req_wen, e.wen);
              chk("req_wmask", bus.mem_req_wmask, e.wmask);
              chk("req_wdata", bus.mem_req_wdata, e.wdata);
            end
          end
        end
        if (bus.wb_valid) begin
          chk("wb_latency", presp, 1);
          if (wb_q.size() == 0) fail_now("wb_unexpected");
          else begin
            w = wb_q.pop_front();
            chk("wb_need_to_wb", bus.wb_need_to_wb, w.need);
            chk("wb_prd", bus.wb_prd, w.prd);
            chk("wb_data", bus.wb_data, w.data);
            chk("wb_robidx_flag", bus.wb_robidx_flag, w.flag);
            chk("wb_robidx", bus.wb_robidx, w.idx);
          end
        end
        pv = bus.mem_req_valid; phs = bus.mem_req_valid && bus.mem_req_ready;
        prev.addr = bus.mem_req_addr; prev.wdata = bus.mem_req_wdata;
        prev.wmask = bus.mem_req_wmask; prev.wen = bus.mem_req_wen;
        presp = bus.mem_resp_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int h0, cnt, n, off;
    bit hs;
    logic [63:0] a, imm;
    bus.issue_valid = 0; bus.issue_src1 = '0; bus.issue_src2 = '0; bus.issue_imm = '0;
    bus.issue_prd = '0; bus.issue_need_to_wb = 0; bus.issue_is_load = 0; bus.issue_is_store = 0;
    bus.issue_ls_size = '0; bus.issue_is_unsigned = 0; bus.issue_robidx_flag = 0;
    bus.issue_robidx = '0; bus.flush_valid = 0; bus.flush_robidx_flag = 0; bus.flush_robidx = '0;

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);

    // load doubleword
    preload(64'h1008, 64'h8877665544332211);
    issue(64'h1000, 64'h0, 64'h8, 8, 0, 0, 1, 7'd5, 0, 6'd1, 1, 1);
    wait_idle();
    // signed / unsigned byte
    preload(64'h2000, 64'h0000000080000000);
    issue(64'h2000, 64'h0, 64'h3, 1, 0, 0, 1, 7'd6, 0, 6'd2, 1, 1);
    issue(64'h2000, 64'h0, 64'h3, 1, 1, 0, 1, 7'd7, 0, 6'd3, 1, 1);
    wait_idle();
    // store word
    issue(64'h3000, 64'hDEADBEEF, 64'h4, 4, 0, 1, 1, 7'd8, 0, 6'd4, 1, 1);
    wait_idle();

    // back-pressure: one handshake, stable fields
    stall_cfg = 5; h0 = hs_count;
    issue(64'h1000, 64'h0, 64'h8, 8, 0, 0, 1, 7'd9, 1, 6'd5, 1, 1);
    wait_idle();
    chk("one_handshake", 64'(hs_count - h0), 1);

    // flush while in REQ, before handshake: withdrawn, no wb
    issue(64'h1000, 64'h0, 64'h8, 8, 0, 0, 1, 7'd10, 0, 6'd10, 0, 0);
    bus.flush_valid = 1; bus.flush_robidx_flag = 0; bus.flush_robidx = 6'd5;
    @(posedge clock); #1 bus.flush_valid = 0;
    @(negedge clock);
    chk("req_flush_withdrawn", bus.mem_req_valid, 0);
    chk("req_flush_idle", bus.issue_ready, 1);
    stall_cfg = 0;

    // flush in WAIT: killed (idx 5) then not killed (idx 12)
    rmin = 5; rmax = 5;
    for (int k = 0; k < 2; k++) begin
      issue(64'h2000, 64'h0, 64'h3, 1, 0, 0, 1, 7'd11, 0, 6'd10, 1, k == 1);
      hs = 0; cnt = 0;
      while (!hs && cnt < 50) begin
        @(negedge clock); hs = bus.mem_req_valid && bus.mem_req_ready; cnt++;
      end
      if (!hs) fail_now("wait_handshake_timeout");
      @(posedge clock); #1;
      bus.flush_valid = 1; bus.flush_robidx_flag = 0; bus.flush_robidx = (k == 0) ? 6'd5 : 6'd12;
      @(posedge clock); #1 bus.flush_valid = 0;
      if (k == 0) begin
        hs = 0; cnt = 0;
        while (!hs && cnt < 50) begin
          @(negedge clock); hs = bus.mem_resp_valid; cnt++;
        end
        if (!hs) fail_now("drain_resp_timeout");
        @(negedge clock);
        chk("drain_issue_ready", bus.issue_ready, 1);
        chk("drain_no_wb", bus.wb_valid, 0);
      end
      wait_idle();
    end
    rmin = 0; rmax = 0;

    // flush concurrent with issue: dropped, then accepted next time
    @(posedge clock); #1;
    bus.issue_valid = 1; bus.issue_src1 = 64'h1000; bus.issue_imm = 64'h8; bus.issue_src2 = '0;
    bus.issue_is_load = 1; bus.issue_is_store = 0; bus.issue_ls_size = 4'b1000;
    bus.issue_robidx_flag = 0; bus.issue_robidx = 6'd20;
    bus.flush_valid = 1; bus.flush_robidx_flag = 0; bus.flush_robidx = 6'd3;
    @(posedge clock); #1 bus.issue_valid = 0; bus.flush_valid = 0;
    @(negedge clock);
    chk("flush_issue_no_req", bus.mem_req_valid, 0);
    chk("flush_issue_idle", bus.issue_ready, 1);
    issue(64'h1000, 64'h0, 64'h8, 8, 0, 0, 1, 7'd12, 0, 6'd20, 1, 1);
    wait_idle();

    // randomized mix of loads and stores
    for (int t = 0; t < 120; t++) begin
      n = 1 << $urandom_range(3, 0);
      off = int'($urandom_range(8 / n - 1, 0)) * n;
      a = 64'h4000 + 64'($urandom_range(31, 0)) * 8 + 64'(off);
      imm = {$urandom(), $urandom()};
      stall_cfg = int'($urandom_range(3, 0));
      rmax = int'($urandom_range(3, 0));
      issue(a - imm, {$urandom(), $urandom()}, imm, n, 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 7'($urandom()),
            1'($urandom_range(1, 0)), 6'($urandom()), 1, 1);
    end
    wait_idle();
    chk("req_queue_drained", 64'(req_q.size()), 0);
    chk("wb_queue_drained", 64'(wb_q.size()), 0);

    // async reset in the middle of an access
    stall_cfg = 8;
    issue(64'h1000, 64'h0, 64'h8, 8, 0, 0, 1, 7'd13, 0, 6'd30, 0, 0);
    @(negedge clock);
    chk("mid_access_req_valid", bus.mem_req_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_req_valid", bus.mem_req_valid, 0);
    chk("async_rst_issue_ready", bus.issue_ready, 1);
    chk("async_rst_wb_valid", bus.wb_valid, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    stall_cfg = 0;
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
